// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared scanner state encoding and display constants.
package seg_scan_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int MAX_DIGITS = 8;
    function automatic logic [MAX_DIGITS-1:0] an_off(input int n);
        logic [MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) r[i] = 1'b1;
        end
        return r;
    endfunction
endpackage

// File: rtl/seg_scan_ctrl_seven_seg.sv
// seven_seg: hex nibble to active-low gfedcba segment pattern.
module seven_seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    localparam logic [6:0] LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    assign seg_o = LUT[hex_i];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered multiplexed hex display scanner with dwell/blank sequencing.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);
    localparam int CNT_MAX = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(an_off(NUM_DIGITS));

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d, idx_nx;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_full_q, pend_full_d, ready_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d, lz_blank;
    logic [6:0]              seg_q, seg_d, dec_seg;
    logic                    dp_q, dp_d, tick_q, tick_d;
    logic                    enter_show, xfer, accept, lit, zero_run;
    logic [3:0]              nibble;

    assign idx_nx = idx_q == IDX_LAST ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        enter_show = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SHOW;
                    idx_d      = '0;
                    cnt_d      = '0;
                    enter_show = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d      = '0;
                        state_d    = BLANK_CYCLES == 0 ? SHOW : GAP;
                        idx_d      = BLANK_CYCLES == 0 ? idx_nx : idx_q;
                        enter_show = BLANK_CYCLES == 0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d      = '0;
                        state_d    = SHOW;
                        idx_d      = idx_nx;
                        enter_show = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The pending frame becomes active only at the start of a frame, so a frame never mixes data.
    always_comb begin
        accept      = load_valid && ready_q;
        xfer        = enter_show && idx_d == '0 && pend_full_q;
        act_data_d  = xfer ? pend_data_q : act_data_q;
        act_dp_d    = xfer ? pend_dp_q : act_dp_q;
        pend_data_d = accept ? load_data : pend_data_q;
        pend_dp_d   = accept ? load_dp : pend_dp_q;
        pend_full_d = accept || (pend_full_q && !xfer);
    end

    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && act_data_d[4*i +: 4] == 4'h0;
            lz_blank[i] = LZ_BLANK && zero_run && !act_dp_d[i];
        end
    end

    // Decode from next-state index and buffer so segments land on the same edge as SHOW entry.
    assign nibble = act_data_d[4*idx_d +: 4];

    seven_seg u_dec (
        .hex_i (nibble),
        .seg_o (dec_seg)
    );

    always_comb begin
        lit    = state_d == SHOW && !lz_blank[idx_d];
        an_d   = lit ? ~(NUM_DIGITS'(1) << idx_d) : AN_OFF;
        seg_d  = lit ? dec_seg : SEG_BLANK;
        dp_d   = lit ? !act_dp_d[idx_d] : 1'b1;
        tick_d = enter_show && idx_d == '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            ready_q     <= !pend_full_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
        end
    end

    assign load_ready = ready_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scoreboard bench for seg_scan_ctrl against a frame-position model.
module tb_seg_scan_ctrl;
    localparam int N = 4, DWELL = 4, BLANK = 1, SLOT = DWELL + BLANK, FRAME = N * SLOT;
    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
        logic       ready;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, enable, load_valid, load_ready, dp, frame_tick;
    logic [15:0] load_data;
    logic [3:0]  load_dp, an;
    logic [6:0]  seg;

    obs_t        exp_q[$];
    int          tests = 0, fails = 0;
    int          pos = -1;
    logic [15:0] m_act = '0, m_pend = '0;
    logic [3:0]  m_act_dp = '0, m_pend_dp = '0;
    bit          m_full = 1'b0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK),
        .LZ_BLANK     (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Expected pins for frame position p (-1 = dark/idle) given the displayed value.
    function automatic obs_t predict(input int p, input logic [15:0] d, input logic [3:0] pdp, input bit full);
        obs_t       o;
        int         dig;
        logic [3:0] nib;
        o.an    = 4'hF;
        o.seg   = 7'h7F;
        o.dp    = 1'b1;
        o.tick  = p == 0;
        o.ready = !full;
        dig     = p < 0 ? 0 : p / SLOT;
        nib     = d[4*dig +: 4];
        if (p >= 0 && p % SLOT < DWELL && !(dig > 0 && (d >> (4 * dig)) == 16'h0 && !pdp[dig])) begin
            o.an  = ~(4'b1 << dig);
            o.seg = HEX7[nib];
            o.dp  = !pdp[dig];
        end
        return o;
    endfunction

    initial forever begin
        bit acc;
        @(posedge clk);
        if (rst) begin
            pos      = -1;
            m_act    = '0;
            m_act_dp = '0;
            m_full   = 1'b0;
        end else begin
            acc = load_valid && !m_full;
            pos = !enable ? -1 : (pos < 0 ? 0 : (pos + 1) % FRAME);
            if (pos == 0 && m_full) begin
                m_act    = m_pend;
                m_act_dp = m_pend_dp;
                m_full   = 1'b0;
            end
            if (acc) begin
                m_pend    = load_data;
                m_pend_dp = load_dp;
                m_full    = 1'b1;
            end
        end
        exp_q.push_back(predict(pos, m_act, m_act_dp, m_full));
    end

    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = {an, seg, dp, frame_tick, load_ready};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL pins t=%0t got an=%b seg=%h dp=%b tick=%b ready=%b want an=%b seg=%h dp=%b tick=%b ready=%b",
                         $time, a.an, a.seg, a.dp, a.tick, a.ready, e.an, e.seg, e.dp, e.tick, e.ready);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        int n = 0;
        load_data  = d;
        load_dp    = p;
        load_valid = 1'b1;
        while (!load_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) begin
            tests++;
            fails++;
            $display("FAIL load_timeout got ready=%b want 1", load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (pos != p && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (pos != p) begin
            tests++;
            fails++;
            $display("FAIL wait_pos got %0d want %0d", pos, p);
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_dp    = '0;
        cycles(3);
        rst = 1'b0;
        load(16'h12AF, 4'b0000);
        cycles(2);
        enable = 1'b1;
        cycles(45);
        load(16'h0005, 4'b0000);
        cycles(45);
        load(16'h0000, 4'b0000);
        cycles(45);
        load(16'h0005, 4'b0100);
        cycles(45);
        wait_pos(7);
        load(16'h1111, 4'b0000);
        load(16'h2222, 4'b0000);
        cycles(60);
        wait_pos(11);
        enable = 1'b0;
        cycles(4);
        enable = 1'b1;
        cycles(30);
        wait_pos(1);
        load(16'hABCD, 4'b1010);
        wait_pos(9);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(30);
        for (int k = 0; k < 1500; k++) begin
            logic [15:0] d;
            for (int j = 0; j < N; j++) d[4*j +: 4] = $urandom_range(0, 1) != 0 ? 4'($urandom) : 4'h0;
            load_data  = d;
            load_dp    = 4'($urandom & $urandom);
            load_valid = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 40) == 0) enable = !enable;
            rst = $urandom_range(0, 200) == 0;
            @(negedge clk);
        end
        load_valid = 1'b0;
        rst        = 1'b0;
        enable     = 1'b1;
        cycles(25);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before %0t", $time);
        $fatal(1);
    end
endmodule
